// File: rtl/clock_set_ctrl.sv
// Push-button user interface for the century clock: view toggle, field edit
// selection, increment strobes with auto-repeat and idle timeout back to run view.
module clock_set_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int REPEAT_DLY  = 25000000,
  parameter int REPEAT_PER  = 5000000,
  parameter int TIMEOUT_CYC = 500000000
) (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic       btn_mode,
  input  logic       btn_sel,
  input  logic       btn_inc,
  output logic       mode,
  output logic [2:0] blink_mode,
  output logic       run_en,
  output logic       inc_sec,
  output logic       inc_min,
  output logic       inc_hour,
  output logic       inc_day,
  output logic       inc_month,
  output logic       inc_year
);

  localparam int REP_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int REP_W   = $clog2(REP_MAX + 1);
  localparam int IDLE_W  = $clog2(TIMEOUT_CYC + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYC - 1);
  localparam logic [REP_W-1:0]  DLY_CNT   = REP_W'(REPEAT_DLY);
  localparam logic [REP_W-1:0]  PER_CNT   = REP_W'(REPEAT_PER);
  localparam logic [REP_W-1:0]  REP_SAT   = REP_W'(REP_MAX);

  typedef enum logic [2:0] {
    RUN_TIME, RUN_DATE, SET_HOUR, SET_MIN, SET_SEC, SET_DAY, SET_MONTH, SET_YEAR
  } state_t;

  logic [2:0]             btn_raw;
  logic [SYNC_STAGES-1:0] sync_reg [3];
  logic [2:0]             sync_lvl;
  logic [2:0]             hist_reg;
  logic [2:0]             ev_reg;
  logic [SYNC_STAGES:0]   ready_reg;

  assign btn_raw = {btn_inc, btn_sel, btn_mode};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_lvl
      assign sync_lvl[gi] = sync_reg[gi][SYNC_STAGES-1];
    end
  endgenerate

  // Edges are only accepted once the sync chain holds post-reset samples,
  // so a button held through reset never produces a spurious press.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 3; b++) sync_reg[b] <= '0;
      hist_reg  <= '0;
      ev_reg    <= '0;
      ready_reg <= '0;
    end else begin
      for (int b = 0; b < 3; b++) sync_reg[b] <= {sync_reg[b][SYNC_STAGES-2:0], btn_raw[b]};
      hist_reg  <= sync_lvl;
      ev_reg    <= sync_lvl & ~hist_reg & {3{ready_reg[SYNC_STAGES]}};
      ready_reg <= {ready_reg[SYNC_STAGES-1:0], 1'b1};
    end
  end

  logic ev_mode, ev_sel, ev_inc, inc_lvl;
  assign ev_mode = ev_reg[0];
  assign ev_sel  = ev_reg[1];
  assign ev_inc  = ev_reg[2];
  assign inc_lvl = sync_lvl[2];

  state_t            state_reg, state_next, home_state;
  logic [IDLE_W-1:0] idle_reg, idle_next;
  logic [REP_W-1:0]  hold_reg, hold_next, hold_inc, rep_target;
  logic              phase_reg, phase_next, armed_reg, armed_next;
  logic              strobe, in_set, time_view;
  logic              mode_reg, mode_next, run_en_reg, run_en_next;
  logic [2:0]        blink_reg, blink_next;
  logic [5:0]        inc_reg, inc_next;

  assign in_set     = (state_reg != RUN_TIME) && (state_reg != RUN_DATE);
  assign time_view  = (state_reg inside {RUN_TIME, SET_HOUR, SET_MIN, SET_SEC});
  assign home_state = time_view ? RUN_TIME : RUN_DATE;

  always_comb begin
    state_next = state_reg;
    idle_next  = '0;
    hold_next  = hold_reg;
    phase_next = phase_reg;
    armed_next = armed_reg;
    strobe     = 1'b0;
    hold_inc   = hold_reg + REP_W'(1);
    rep_target = phase_reg ? PER_CNT : DLY_CNT;
    if (ev_mode || ev_sel || (in_set && idle_reg == IDLE_LAST)) begin
      hold_next  = '0;
      phase_next = 1'b0;
      armed_next = 1'b0;
      if (ev_mode) begin
        if (state_reg == RUN_TIME)      state_next = RUN_DATE;
        else if (state_reg == RUN_DATE) state_next = RUN_TIME;
        else                            state_next = home_state;
      end else if (ev_sel) begin
        case (state_reg)
          RUN_TIME:  state_next = SET_HOUR;
          RUN_DATE:  state_next = SET_DAY;
          SET_HOUR:  state_next = SET_MIN;
          SET_MIN:   state_next = SET_SEC;
          SET_SEC:   state_next = RUN_TIME;
          SET_DAY:   state_next = SET_MONTH;
          SET_MONTH: state_next = SET_YEAR;
          SET_YEAR:  state_next = RUN_DATE;
          default:   state_next = RUN_TIME;
        endcase
      end else begin
        state_next = home_state;
      end
    end else if (ev_inc) begin
      if (in_set) begin
        strobe     = 1'b1;
        armed_next = 1'b1;
        hold_next  = '0;
        phase_next = 1'b0;
      end
    end else begin
      if (in_set && !inc_lvl && idle_reg != IDLE_LAST) idle_next = idle_reg + IDLE_W'(1);
      if (!inc_lvl) begin
        hold_next  = '0;
        phase_next = 1'b0;
        armed_next = 1'b0;
      end else if (armed_reg) begin
        // First repeat after REPEAT_DLY, then every REPEAT_PER while held.
        if (hold_inc == rep_target) begin
          strobe     = 1'b1;
          hold_next  = '0;
          phase_next = 1'b1;
        end else if (hold_reg != REP_SAT) begin
          hold_next = hold_inc;
        end
      end
    end
  end

  always_comb begin
    mode_next   = 1'b1;
    blink_next  = 3'b000;
    run_en_next = 1'b1;
    case (state_next)
      RUN_DATE:  mode_next = 1'b0;
      SET_HOUR:  begin blink_next = 3'b011; run_en_next = 1'b0; end
      SET_MIN:   begin blink_next = 3'b010; run_en_next = 1'b0; end
      SET_SEC:   begin blink_next = 3'b001; run_en_next = 1'b0; end
      SET_DAY:   begin mode_next = 1'b0; blink_next = 3'b100; end
      SET_MONTH: begin mode_next = 1'b0; blink_next = 3'b101; end
      SET_YEAR:  begin mode_next = 1'b0; blink_next = 3'b110; end
      default:   mode_next = 1'b1;
    endcase
    inc_next = '0;
    if (strobe) begin
      case (state_reg)
        SET_SEC:   inc_next = 6'b000001;
        SET_MIN:   inc_next = 6'b000010;
        SET_HOUR:  inc_next = 6'b000100;
        SET_DAY:   inc_next = 6'b001000;
        SET_MONTH: inc_next = 6'b010000;
        SET_YEAR:  inc_next = 6'b100000;
        default:   inc_next = 6'b000000;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= RUN_TIME;
      idle_reg   <= '0;
      hold_reg   <= '0;
      phase_reg  <= 1'b0;
      armed_reg  <= 1'b0;
      mode_reg   <= 1'b1;
      blink_reg  <= 3'b000;
      run_en_reg <= 1'b1;
      inc_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      idle_reg   <= idle_next;
      hold_reg   <= hold_next;
      phase_reg  <= phase_next;
      armed_reg  <= armed_next;
      mode_reg   <= mode_next;
      blink_reg  <= blink_next;
      run_en_reg <= run_en_next;
      inc_reg    <= inc_next;
    end
  end

  assign mode       = mode_reg;
  assign blink_mode = blink_reg;
  assign run_en     = run_en_reg;
  assign {inc_year, inc_month, inc_day, inc_hour, inc_min, inc_sec} = inc_reg;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Bench for clock_set_ctrl: directed scenarios then random button traffic,
// every cycle compared against a behavioural model of the button interface.
module tb_clock_set_ctrl;

  localparam int DLY = 20;
  localparam int PER = 5;
  localparam int TMO = 100;

  logic       clk_in = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_mode = 1'b0, btn_sel = 1'b0, btn_inc = 1'b0;
  logic       mode, run_en;
  logic [2:0] blink_mode;
  logic       inc_sec, inc_min, inc_hour, inc_day, inc_month, inc_year;

  int checks = 0;
  int errors = 0;

  always #5 clk_in = ~clk_in;

  clock_set_ctrl #(
    .SYNC_STAGES(2), .REPEAT_DLY(DLY), .REPEAT_PER(PER), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk_in(clk_in), .rst_n(rst_n),
    .btn_mode(btn_mode), .btn_sel(btn_sel), .btn_inc(btn_inc),
    .mode(mode), .blink_mode(blink_mode), .run_en(run_en),
    .inc_sec(inc_sec), .inc_min(inc_min), .inc_hour(inc_hour),
    .inc_day(inc_day), .inc_month(inc_month), .inc_year(inc_year)
  );

  // Model: view (1 = time), field (0 = running, 1..3 = fields in edit order),
  // idle cycles, cycles held since the press, and raw button sample history.
  int         m_view, m_field, m_idle, m_held, m_nsamp;
  bit         m_armed;
  logic [4:0] m_hist [3];
  logic       exp_mode, exp_run;
  logic [2:0] exp_blink;
  logic [5:0] exp_inc;
  int         seen_inc [6];

  function automatic logic [2:0] blink_of(int view, int field);
    if (field == 0) return 3'd0;
    return view != 0 ? 3'(4 - field) : 3'(3 + field);
  endfunction

  task automatic chk(string tag, logic [7:0] got, logic [7:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic model_reset();
    m_view = 1; m_field = 0; m_idle = 0; m_held = 0; m_nsamp = 0; m_armed = 0;
    for (int b = 0; b < 3; b++) m_hist[b] = '0;
    exp_mode = 1'b1; exp_blink = 3'd0; exp_run = 1'b1; exp_inc = '0;
  endtask

  task automatic clear_seen();
    for (int i = 0; i < 6; i++) seen_inc[i] = 0;
  endtask

  task automatic model_step();
    logic [2:0] btn, ev;
    logic       lvl, strobe, in_set;
    logic [2:0] cur_blink;
    btn = {btn_inc, btn_sel, btn_mode};
    for (int b = 0; b < 3; b++) m_hist[b] = {m_hist[b][3:0], btn[b]};
    if (m_nsamp < 1000) m_nsamp++;
    // A press is visible 3 cycles after its first sample and needs a low
    // post-reset sample before it; the held level lags the button by 2 cycles.
    lvl = (m_nsamp >= 3) && m_hist[2][2];
    for (int b = 0; b < 3; b++) ev[b] = (m_nsamp >= 5) && m_hist[b][3] && !m_hist[b][4];
    strobe = 1'b0;
    in_set = (m_field != 0);
    cur_blink = blink_of(m_view, m_field);
    if (ev[0] || ev[1] || (in_set && m_idle == TMO - 1)) begin
      if (ev[0]) begin
        if (!in_set) m_view = 1 - m_view;
        m_field = 0;
      end else if (ev[1]) begin
        m_field = (m_field == 3) ? 0 : m_field + 1;
      end else begin
        m_field = 0;
      end
      m_idle = 0; m_armed = 0; m_held = 0;
    end else if (ev[2]) begin
      m_idle = 0;
      if (in_set) begin strobe = 1'b1; m_armed = 1; m_held = 0; end
    end else begin
      m_idle = (in_set && !lvl) ? m_idle + 1 : 0;
      if (!lvl) begin
        m_armed = 0; m_held = 0;
      end else if (m_armed) begin
        m_held++;
        if (m_held == DLY || (m_held > DLY && (m_held - DLY) % PER == 0)) strobe = 1'b1;
      end
    end
    exp_mode  = (m_view != 0);
    exp_blink = blink_of(m_view, m_field);
    exp_run   = !(m_view != 0 && m_field != 0);
    exp_inc   = strobe ? 6'(1 << (cur_blink - 1)) : 6'd0;
  endtask

  task automatic tick();
    logic [5:0] inc_obs;
    @(posedge clk_in);
    model_step();
    #1;
    inc_obs = {inc_year, inc_month, inc_day, inc_hour, inc_min, inc_sec};
    for (int i = 0; i < 6; i++) if (inc_obs[i]) seen_inc[i]++;
    chk("mode", 8'(mode), 8'(exp_mode));
    chk("blink", 8'(blink_mode), 8'(exp_blink));
    chk("run_en", 8'(run_en), 8'(exp_run));
    chk("inc", 8'(inc_obs), 8'(exp_inc));
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic press_sel();
    btn_sel = 1'b1; ticks(3); btn_sel = 1'b0; ticks(6);
  endtask

  task automatic press_mode();
    btn_mode = 1'b1; ticks(3); btn_mode = 1'b0; ticks(6);
  endtask

  task automatic chk_reset_outputs(string tag);
    chk({tag, "_mode"}, 8'(mode), 8'd1);
    chk({tag, "_blink"}, 8'(blink_mode), 8'd0);
    chk({tag, "_run_en"}, 8'(run_en), 8'd1);
    chk({tag, "_inc"}, 8'({inc_year, inc_month, inc_day, inc_hour, inc_min, inc_sec}), 8'd0);
  endtask

  initial begin
    int total, mask, dur;
    model_reset();
    clear_seen();
    repeat (3) @(posedge clk_in);
    #1;
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    ticks(8);
    $display("step 0: reset released, RUN_TIME");

    // 1: view toggle, 4-cycle latency
    btn_mode = 1'b1;
    ticks(3);
    chk("t1_mode_before", 8'(mode), 8'd1);
    tick();
    chk("t1_mode_after", 8'(mode), 8'd0);
    chk("t1_blink", 8'(blink_mode), 8'd0);
    ticks(6); btn_mode = 1'b0; ticks(10);
    btn_mode = 1'b1; ticks(10); btn_mode = 1'b0; ticks(10);
    chk("t1_mode_back", 8'(mode), 8'd1);
    $display("step 1: mode toggled to date and back");

    // 2: edit hour, single increment, walk the time fields back to run
    press_sel();
    chk("t2_blink_hour", 8'(blink_mode), 8'd3);
    chk("t2_run_en", 8'(run_en), 8'd0);
    clear_seen();
    btn_inc = 1'b1; ticks(3); btn_inc = 1'b0; ticks(6);
    chk("t2_inc_hour_cnt", 8'(seen_inc[2]), 8'd1);
    press_sel(); press_sel(); press_sel();
    chk("t2_blink_run", 8'(blink_mode), 8'd0);
    chk("t2_run_en_back", 8'(run_en), 8'd1);
    $display("step 2: hour edit with one increment, back to RUN_TIME");

    // 3: auto-repeat on the day field
    press_mode();
    press_sel();
    chk("t3_blink_day", 8'(blink_mode), 8'd4);
    clear_seen();
    btn_inc = 1'b1; ticks(40); btn_inc = 1'b0; ticks(20);
    chk("t3_inc_day_cnt", 8'(seen_inc[3]), 8'd5);
    $display("step 3: day held 40 cycles, %0d strobes", seen_inc[3]);

    // 4: idle timeout from SET_MONTH
    btn_sel = 1'b1; ticks(2); btn_sel = 1'b0;
    for (int i = 0; i < 10 && blink_mode != 3'd5; i++) tick();
    chk("t4_enter_month", 8'(blink_mode), 8'd5);
    ticks(TMO - 1);
    chk("t4_still_month", 8'(blink_mode), 8'd5);
    tick();
    chk("t4_timeout_blink", 8'(blink_mode), 8'd0);
    chk("t4_timeout_mode", 8'(mode), 8'd0);
    $display("step 4: SET_MONTH timed out to RUN_DATE");

    // 5: simultaneous presses in SET_MIN, mode wins
    press_mode();
    press_sel(); press_sel();
    chk("t5_blink_min", 8'(blink_mode), 8'd2);
    clear_seen();
    btn_mode = 1'b1; btn_sel = 1'b1; btn_inc = 1'b1;
    ticks(3);
    btn_mode = 1'b0; btn_sel = 1'b0; btn_inc = 1'b0;
    ticks(8);
    chk("t5_blink", 8'(blink_mode), 8'd0);
    chk("t5_mode", 8'(mode), 8'd1);
    chk("t5_inc_min_cnt", 8'(seen_inc[1]), 8'd0);
    $display("step 5: simultaneous presses aborted SET_MIN");

    // 6: reset in the middle of a held increment
    press_sel(); press_sel(); press_sel();
    chk("t6_blink_sec", 8'(blink_mode), 8'd1);
    btn_inc = 1'b1;
    ticks(6);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("t6_async");
    @(posedge clk_in);
    #1;
    rst_n = 1'b1;
    model_reset();
    clear_seen();
    ticks(30); btn_inc = 1'b0; ticks(10);
    total = 0;
    for (int i = 0; i < 6; i++) total += seen_inc[i];
    chk("t6_no_strobes", 8'(total), 8'd0);
    chk("t6_blink", 8'(blink_mode), 8'd0);
    $display("step 6: reset during SET_SEC with inc held");

    // random button traffic against the model
    for (int s = 0; s < 60; s++) begin
      mask = $urandom_range(0, 7);
      dur  = $urandom_range(1, 35);
      if ($urandom_range(0, 4) == 0) begin mask = 0; dur = $urandom_range(60, 130); end
      btn_mode = mask[0]; btn_sel = mask[1]; btn_inc = mask[2];
      ticks(dur);
      $display("rand %0d: buttons %03b for %0d cycles, blink %0d", s, mask[2:0], dur, blink_mode);
    end
    btn_mode = 1'b0; btn_sel = 1'b0; btn_inc = 1'b0;
    ticks(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
